// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serialising pattern-detector controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: FSM state encoding, power-on detector configuration, length check.
package seq_detect_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Power-on configuration reproduces the classic 1101 non-overlapping detector.
  localparam logic [3:0] RST_PATTERN = 4'b1101;
  localparam logic [3:0] RST_LEN     = 4'd4;
  localparam logic       RST_OVERLAP = 1'b0;

  // A pattern length is usable only if it is non-zero and fits the history.
  function automatic logic len_legal(input logic [3:0] len, input logic [3:0] pat_max);
    return (len != 4'd0) && (len <= pat_max);
  endfunction

endpackage

// File: rtl/seq_pattern_core.sv
// Programmable Moore pattern detector fed one bit per cycle.
// Latency: o_match rises the cycle after the edge that shifts in the completing bit.
// Backpressure: none; a bit is consumed on every edge where i_bit_vld is high.
// Ports: i_clk/i_rst clock and sync reset; i_clear wipes history and any pending match;
//        i_bit_vld/i_bit_dat serial input; i_pattern/i_len/i_overlap configuration;
//        o_match registered one-cycle hit pulse.
module seq_pattern_core
  import seq_detect_ctrl_pkg::*;
#(
  parameter int PAT_MAX = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_bit_vld,
  input  logic               i_bit_dat,
  input  logic [PAT_MAX-1:0] i_pattern,
  input  logic [3:0]         i_len,
  input  logic               i_overlap,
  output logic               o_match
);

  localparam logic [3:0] FILL_MAX = 4'(PAT_MAX);

  logic [PAT_MAX-1:0] r_hist;
  logic [3:0]         r_fill;
  logic               r_match;

  logic [PAT_MAX-1:0] w_next_hist;
  logic [PAT_MAX-1:0] w_mask;
  logic [3:0]         w_next_fill;
  logic               w_next_hit;

  always_comb begin
    w_next_hist = (r_hist << 1) | PAT_MAX'(i_bit_dat);
    w_next_fill = (r_fill == FILL_MAX) ? r_fill : r_fill + 4'd1;
    // Only the low i_len history bits take part in the compare.
    w_mask      = ~({PAT_MAX{1'b1}} << i_len);
    // fill gating keeps a non-overlapping hit from reusing its own bits.
    w_next_hit  = (w_next_fill >= i_len) &&
                  ((w_next_hist & w_mask) == (i_pattern & w_mask));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= i_bit_vld && w_next_hit;
      if (i_bit_vld) begin
        r_hist <= w_next_hist;
        r_fill <= (w_next_hit && !i_overlap) ? 4'd0 : w_next_fill;
      end
    end
  end

  assign o_match = r_match;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serialiser driving a programmable pattern detector, with match counting.
// Latency: first bit enters the detector one edge after the handshake; match one edge later.
// Backpressure: o_in_ready high in IDLE and on the last bit of a word (gapless streaming).
// Ports: i_clk/i_rst sync active-high reset; i_cfg_* configuration write (o_cfg_err on reject);
//        i_in_valid/i_in_data/o_in_ready word handshake; o_match, o_match_count, o_busy status.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [PAT_MAX-1:0] i_cfg_pattern,
  input  logic [3:0]         i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_in_valid,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_in_ready,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_busy,
  output logic               o_cfg_err
);

  localparam int                 IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [PAT_MAX-1:0] PAT_RST  = PAT_MAX'(RST_PATTERN);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DATA_W-1:0]  r_shreg;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [PAT_MAX-1:0] r_pattern;
  logic [3:0]         r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_count;
  logic               r_cfg_err;

  logic w_in_ready;
  logic w_hs;
  logic w_last_bit;
  logic w_bit_vld;
  logic w_bit_dat;
  logic w_cfg_accept;
  logic w_cfg_reject;
  logic w_match;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_bit_vld   = 1'b0;
    w_last_bit  = (r_bit_idx == '0);
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_bit_vld  = 1'b1;
        // Accepting on the final bit lets the next word follow with no bubble.
        w_in_ready = w_last_bit;
        if (w_last_bit && !i_in_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_hs         = i_in_valid && w_in_ready;
    w_bit_dat    = r_shreg[r_bit_idx];
    w_cfg_accept = i_cfg_we && (r_state == ST_IDLE) && len_legal(i_cfg_len, 4'(PAT_MAX));
    w_cfg_reject = i_cfg_we && !w_cfg_accept;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else if (w_hs) begin
      r_shreg   <= i_in_data;
      r_bit_idx <= IDX_LAST;
    end else if (w_bit_vld && !w_last_bit) begin
      r_bit_idx <= r_bit_idx - IDX_W'(1);
    end
  end

  // Config only changes while idle, so the detector never sees a mid-word switch.
  // A word accepted in the same cycle starts shifting after the new config is live.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pattern <= PAT_RST;
      r_len     <= RST_LEN;
      r_overlap <= RST_OVERLAP;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_reject;
      if (w_cfg_accept) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= i_cfg_len;
        r_overlap <= i_cfg_overlap;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_cfg_accept)               r_count <= '0;
    else if (w_match && (r_count != CNT_MAX)) r_count <= r_count + CNT_W'(1);
  end

  seq_pattern_core #(
    .PAT_MAX (PAT_MAX)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_cfg_accept),
    .i_bit_vld (w_bit_vld),
    .i_bit_dat (w_bit_dat),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .i_overlap (r_overlap),
    .o_match   (w_match)
  );

  assign o_in_ready    = w_in_ready;
  assign o_match       = w_match;
  assign o_match_count = r_count;
  assign o_busy        = (r_state == ST_SHIFT);
  assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: default-width instance plus a CNT_W=2 instance.
// Both share stimulus; match history is logged per cycle as a bit string (newest at LSB).
// Summary line reports total compares and mismatches.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready,  match,  busy,  cfg_err;
  logic [7:0] match_count;
  logic       in_ready2, match2, busy2, cfg_err2;
  logic [1:0] match_count2;

  logic [31:0] mlog;
  logic [31:0] mlog2;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_match(match),
    .o_match_count(match_count), .o_busy(busy), .o_cfg_err(cfg_err)
  );

  seq_detect_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready2), .o_match(match2),
    .o_match_count(match_count2), .o_busy(busy2), .o_cfg_err(cfg_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mlog  = {mlog[30:0], match};
    mlog2 = {mlog2[30:0], match2};
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mlog = '0; mlog2 = '0;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  // Handshake one word, then run to its last bit (bit_idx 0, ready for the next word).
  task automatic send(input string tag, input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    chk({tag, "_rdy_hs"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_hs"}, busy, 1);
    chk({tag, "_rdy_mid"}, in_ready, 0);
    repeat (7) tick();
    chk({tag, "_rdy_last"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0; mlog = '0; mlog2 = '0;

    // 1: reset state, default 1101 detector on 0xD0
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_count, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_rdy2", in_ready2, 1);
    chk("rst_err2", cfg_err2, 0);
    send("t1", 8'hD0);
    tick();
    tick();
    chk("t1_mlog", mlog[9:0], 10'b0000100000);
    chk("t1_cnt", match_count, 1);
    chk("t1_idle", busy, 0);

    // 2: non-overlap vs overlap on 0xDB
    do_reset();
    send("t2a", 8'hDB);
    tick();
    tick();
    chk("t2a_mlog", mlog[9:0], 10'b0000100000);
    chk("t2a_cnt", match_count, 1);
    cfg_write(8'h0D, 4'd4, 1'b1);
    chk("t2_cfg_err", cfg_err, 0);
    chk("t2_cnt_clr", match_count, 0);
    mlog = '0;
    send("t2b", 8'hDB);
    tick();
    tick();
    chk("t2b_mlog", mlog[9:0], 10'b0000100100);
    chk("t2b_cnt", match_count, 2);

    // 3: pattern straddling two back-to-back words
    do_reset();
    send("t3w1", 8'h01);
    send("t3w2", 8'hA0);
    tick();
    tick();
    chk("t3_mlog", mlog[17:0], 18'b000000000001000000);
    chk("t3_cnt", match_count, 1);

    // 4: rejected config writes keep the old config
    do_reset();
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    cfg_write(8'h07, 4'd3, 1'b1);
    chk("t4_err_shift", cfg_err, 1);
    tick();
    chk("t4_err_pulse", cfg_err, 0);
    repeat (5) tick();
    tick();
    chk("t4_idle", busy, 0);
    cfg_write(8'hFF, 4'd0, 1'b1);
    chk("t4_err_len0", cfg_err, 1);
    cfg_write(8'h0D, 4'd9, 1'b0);
    chk("t4_err_len9", cfg_err, 1);
    tick();
    chk("t4_err_drop", cfg_err, 0);
    mlog = '0;
    send("t4", 8'hD0);
    tick();
    tick();
    chk("t4_mlog", mlog[9:0], 10'b0000100000);
    chk("t4_cnt", match_count, 1);

    // 5: single-bit pattern, overlap, counter saturation on the narrow instance
    do_reset();
    cfg_write(8'h01, 4'd1, 1'b1);
    mlog = '0; mlog2 = '0;
    send("t5", 8'hFF);
    tick();
    tick();
    chk("t5_mlog", mlog[9:0], 10'b0111111110);
    chk("t5_mlog2", mlog2[9:0], 10'b0111111110);
    chk("t5_cnt", match_count, 8);
    chk("t5_cnt_sat", match_count2, 3);

    // 6: reset mid-word aborts before the completing bit
    do_reset();
    in_valid = 1'b1; in_data = 8'hD0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_rdy", in_ready, 1);
    chk("t6_cnt", match_count, 0);
    chk("t6_match", match, 0);
    mlog = '0;
    repeat (6) tick();
    chk("t6_mlog", mlog[5:0], 6'b000000);
    chk("t6_cnt_end", match_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
